// File: rtl/fire7_sq_pkg.sv
// fire7_sq_pkg
// Shared definitions for the fire7 squeeze post-accumulation stage:
//   NUM_CH    - squeeze channels per pixel
//   BIAS_W    - width of one sign-magnitude bias word
//   CH_W      - channel index width
//   ch_idx_t  - channel index type
//   sm_to_tc  - sign-magnitude to two's complement conversion of a bias word
package fire7_sq_pkg;
    localparam int NUM_CH = 64;
    localparam int BIAS_W = 16;
    localparam int CH_W   = $clog2(NUM_CH);

    typedef logic [CH_W-1:0] ch_idx_t;

    // Bit BIAS_W-1 is the sign, the rest is the magnitude. Negative zero
    // (sign set, magnitude 0) naturally maps to 0.
    function automatic logic signed [BIAS_W-1:0] sm_to_tc(input logic [BIAS_W-1:0] sm);
        logic signed [BIAS_W-1:0] mag;
        mag = {1'b0, sm[BIAS_W-2:0]};
        return sm[BIAS_W-1] ? -mag : mag;
    endfunction
endpackage

// File: rtl/fire7_squeeze_bias_relu_if.sv
// fire7_squeeze_bias_relu_if
// Stream bus of the squeeze bias/ReLU stage: accumulator input stream and
// activation output stream, each with valid/ready.
//   slave  - the stage itself (consumes in_*, produces out_*)
//   master - the environment (produces in_*, consumes out_*)
interface fire7_squeeze_bias_relu_if #(
    parameter int ACC_W = 32,
    parameter int OUT_W = 16,
    parameter int CH_W  = fire7_sq_pkg::CH_W
);
    logic             in_valid;
    logic             in_ready;
    logic [ACC_W-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [CH_W-1:0]  out_ch;
    logic             out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch, out_last
    );
endinterface

// File: rtl/fire7_sq_requant.sv
// fire7_sq_requant
// Combinational requantiser: optional round-half-up right shift, ReLU and
// saturation to a non-negative OUT_W-bit two's complement activation.
//   sum_in   - signed value at accumulator scale (IN_W bits)
//   data_out - activation in [0, 2^(OUT_W-1)-1]
//   clip_hi  - result was clipped to the positive maximum
//   clip_lo  - result was negative and zeroed by ReLU
module fire7_sq_requant #(
    parameter int IN_W  = 33,
    parameter int OUT_W = 16,
    parameter int SHR   = 0
) (
    input  logic signed [IN_W-1:0] sum_in,
    output logic [OUT_W-1:0]       data_out,
    output logic                   clip_hi,
    output logic                   clip_lo
);
    // One extra bit so the rounding increment can never wrap.
    localparam int EXT_W = IN_W + 1;
    localparam logic signed [EXT_W-1:0] MAX_POS = (EXT_W'(1) <<< (OUT_W-1)) - EXT_W'(1);

    logic signed [EXT_W-1:0] ext;
    logic signed [EXT_W-1:0] rounded;
    logic signed [EXT_W-1:0] shifted;

    assign ext = {sum_in[IN_W-1], sum_in};

    generate
        if (SHR > 0) begin : g_round
            localparam logic signed [EXT_W-1:0] HALF = EXT_W'(1) <<< (SHR-1);
            assign rounded = ext + HALF;
        end else begin : g_no_round
            assign rounded = ext;
        end
    endgenerate

    assign shifted = rounded >>> SHR;

    always_comb begin
        clip_lo  = shifted[EXT_W-1];
        clip_hi  = !shifted[EXT_W-1] && (shifted > MAX_POS);
        data_out = shifted[OUT_W-1:0];
        if (clip_lo) begin
            data_out = '0;
        end else if (clip_hi) begin
            data_out = MAX_POS[OUT_W-1:0];
        end
    end
endmodule

// File: rtl/fire7_squeeze_bias_relu.sv
// fire7_squeeze_bias_relu
// Post-accumulation stage of the fire7 squeeze layer. Each accepted
// accumulator word is tagged with its channel, has the channel's
// sign-magnitude bias added (S1), then is rounded/shifted, ReLU'd and
// saturated (S2) before streaming to the expand-stage input buffer.
// Two-stage valid/ready pipeline, full backpressure, 1 word/cycle.
//   clk, rst  - clock, asynchronous active-high reset
//   ch_clr    - synchronous channel counter restart (new frame)
//   bias_mem  - NUM_CH sign-magnitude bias words
//   bus       - in_* accumulator stream, out_* activation stream + channel tag
// Optional build macro FIRE7_SQ_SAT_CNT_EN adds sat_cnt / relu_cnt outputs
// (saturating 16-bit counts of high-clipped and ReLU-zeroed results).
module fire7_squeeze_bias_relu
    import fire7_sq_pkg::*;
#(
    parameter int ACC_W    = 32,
    parameter int OUT_W    = 16,
    parameter int BIAS_SHL = 0,
    parameter int OUT_SHR  = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ch_clr,
    input  logic [NUM_CH-1:0][BIAS_W-1:0]  bias_mem,
    fire7_squeeze_bias_relu_if.slave       bus
`ifdef FIRE7_SQ_SAT_CNT_EN
    ,
    output logic [15:0]                    sat_cnt,
    output logic [15:0]                    relu_cnt
`endif
);
    localparam int SUM_W = ACC_W + 1;
    localparam ch_idx_t LAST_CH = ch_idx_t'(NUM_CH-1);

    ch_idx_t                   ch_cnt_q, ch_cnt_d;
    logic                      s1_valid_q, s1_valid_d;
    logic signed [SUM_W-1:0]   s1_sum_q, s1_sum_d;
    ch_idx_t                   s1_ch_q, s1_ch_d;
    logic                      s2_valid_q, s2_valid_d;
    logic [OUT_W-1:0]          out_data_q, out_data_d;
    ch_idx_t                   out_ch_q, out_ch_d;
    logic                      out_last_q, out_last_d;

    logic                      s1_ready, in_ready, in_fire, s1_move;
    ch_idx_t                   ch_tag;
    logic signed [BIAS_W-1:0]  bias_tc;
    logic signed [SUM_W-1:0]   bias_ext, in_ext;
    logic [OUT_W-1:0]          rq_data;
    logic                      rq_clip_hi, rq_clip_lo;

    // Readies depend only on registered valids, never on in_valid.
    assign s1_ready = !s2_valid_q || bus.out_ready;
    assign in_ready = !s1_valid_q || s1_ready;
    assign in_fire  = bus.in_valid && in_ready;
    assign s1_move  = s1_valid_q && s1_ready;

    // A beat accepted together with ch_clr belongs to channel 0.
    assign ch_tag   = ch_clr ? '0 : ch_cnt_q;
    assign bias_tc  = sm_to_tc(bias_mem[ch_tag]);
    assign bias_ext = {{(SUM_W-BIAS_W){bias_tc[BIAS_W-1]}}, bias_tc} <<< BIAS_SHL;
    assign in_ext   = {bus.in_data[ACC_W-1], bus.in_data};

    fire7_sq_requant #(
        .IN_W  (SUM_W),
        .OUT_W (OUT_W),
        .SHR   (OUT_SHR)
    ) u_requant (
        .sum_in   (s1_sum_q),
        .data_out (rq_data),
        .clip_hi  (rq_clip_hi),
        .clip_lo  (rq_clip_lo)
    );

    always_comb begin
        ch_cnt_d   = ch_cnt_q;
        s1_valid_d = s1_valid_q;
        s1_sum_d   = s1_sum_q;
        s1_ch_d    = s1_ch_q;
        s2_valid_d = s2_valid_q;
        out_data_d = out_data_q;
        out_ch_d   = out_ch_q;
        out_last_d = out_last_q;

        if (ch_clr) begin
            ch_cnt_d = '0;
        end
        if (in_fire) begin
            ch_cnt_d = (ch_tag == LAST_CH) ? '0 : ch_tag + 1'b1;
        end

        if (in_ready) begin
            s1_valid_d = bus.in_valid;
        end
        if (in_fire) begin
            s1_sum_d = in_ext + bias_ext;
            s1_ch_d  = ch_tag;
        end

        if (s1_ready) begin
            s2_valid_d = s1_valid_q;
        end
        if (s1_move) begin
            out_data_d = rq_data;
            out_ch_d   = s1_ch_q;
            out_last_d = (s1_ch_q == LAST_CH);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_cnt_q   <= '0;
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
            s1_ch_q    <= '0;
            s2_valid_q <= 1'b0;
            out_data_q <= '0;
            out_ch_q   <= '0;
            out_last_q <= 1'b0;
        end else begin
            ch_cnt_q   <= ch_cnt_d;
            s1_valid_q <= s1_valid_d;
            s1_sum_q   <= s1_sum_d;
            s1_ch_q    <= s1_ch_d;
            s2_valid_q <= s2_valid_d;
            out_data_q <= out_data_d;
            out_ch_q   <= out_ch_d;
            out_last_q <= out_last_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_last  = out_last_q;

`ifdef FIRE7_SQ_SAT_CNT_EN
    // Event 0: clipped high, event 1: zeroed by ReLU. Counted as the word
    // moves into S2; ch_clr wins over a coincident event.
    logic [1:0] stat_evt;
    assign stat_evt = {rq_clip_lo, rq_clip_hi};

    for (genvar gi = 0; gi < 2; gi++) begin : g_stat
        logic [15:0] cnt_q, cnt_d;
        always_comb begin
            cnt_d = cnt_q;
            if (ch_clr) begin
                cnt_d = '0;
            end else if (s1_move && stat_evt[gi] && (cnt_q != 16'hFFFF)) begin
                cnt_d = cnt_q + 16'd1;
            end
        end
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

    assign sat_cnt  = g_stat[0].cnt_q;
    assign relu_cnt = g_stat[1].cnt_q;
`else
    logic unused_clip;
    assign unused_clip = rq_clip_hi ^ rq_clip_lo;
`endif
endmodule

// File: tb/tb_fire7_squeeze_bias_relu.sv
// tb_fire7_squeeze_bias_relu
// Two instances (OUT_SHR = 0 and OUT_SHR = 4) share one stimulus stream.
// A queue-based reference model predicts every output word from the bias
// table and plain integer arithmetic; a negedge compare process checks both
// instances whenever out_valid is high. Directed beats pin the model with
// hand-computed values, then randomized traffic with random backpressure.
module tb_fire7_squeeze_bias_relu;
    import fire7_sq_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ch_clr = 1'b0;
    logic [NUM_CH-1:0][15:0] bias_mem;
    logic in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic out_ready = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    int n_out = 0;

    always #5 clk = ~clk;

    fire7_squeeze_bias_relu_if #(.ACC_W(32), .OUT_W(16)) bus0 ();
    fire7_squeeze_bias_relu_if #(.ACC_W(32), .OUT_W(16)) bus4 ();

    assign bus0.in_valid  = in_valid;
    assign bus0.in_data   = in_data;
    assign bus0.out_ready = out_ready;
    assign bus4.in_valid  = in_valid;
    assign bus4.in_data   = in_data;
    assign bus4.out_ready = out_ready;

`ifdef FIRE7_SQ_SAT_CNT_EN
    logic [15:0] sat0, relu0, sat4, relu4;
`endif

    fire7_squeeze_bias_relu #(.OUT_SHR(0)) dut0 (
        .clk(clk), .rst(rst), .ch_clr(ch_clr), .bias_mem(bias_mem), .bus(bus0)
`ifdef FIRE7_SQ_SAT_CNT_EN
        , .sat_cnt(sat0), .relu_cnt(relu0)
`endif
    );

    fire7_squeeze_bias_relu #(.OUT_SHR(4)) dut4 (
        .clk(clk), .rst(rst), .ch_clr(ch_clr), .bias_mem(bias_mem), .bus(bus4)
`ifdef FIRE7_SQ_SAT_CNT_EN
        , .sat_cnt(sat4), .relu_cnt(relu4)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          ch;
        logic [15:0] d0;
        logic [15:0] d4;
    } exp_t;

    exp_t exp_q[$];
    int   model_cnt = 0;

    function automatic longint bias_val(input int ch);
        logic [15:0] b;
        longint mag;
        b = bias_mem[ch];
        mag = longint'(b[14:0]);
        return b[15] ? -mag : mag;
    endfunction

    function automatic logic [15:0] ref_out(input longint acc, input int ch, input int shr);
        longint v;
        v = acc + bias_val(ch);
        if (shr > 0) v = (v + (longint'(1) << (shr - 1))) >>> shr;
        if (v < 0) return 16'd0;
        if (v > 32767) return 16'h7FFF;
        return v[15:0];
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            exp_q.delete();
            model_cnt = 0;
        end else begin
            if (bus0.out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("out_valid_idle", {63'd0, bus0.out_valid}, 64'd0);
                end else begin
                    e = exp_q[0];
                    chk("out_data", {48'd0, bus0.out_data}, {48'd0, e.d0});
                    chk("out_ch", {58'd0, bus0.out_ch}, 64'(e.ch));
                    chk("out_last", {63'd0, bus0.out_last}, {63'd0, (e.ch == NUM_CH-1)});
                    chk("shr4_valid", {63'd0, bus4.out_valid}, 64'd1);
                    chk("shr4_data", {48'd0, bus4.out_data}, {48'd0, e.d4});
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        n_out++;
                    end
                end
            end
            if (ch_clr) model_cnt = 0;
            if (in_valid && bus0.in_ready) begin
                e.ch = model_cnt;
                e.d0 = ref_out(longint'($signed(in_data)), model_cnt, 0);
                e.d4 = ref_out(longint'($signed(in_data)), model_cnt, 4);
                exp_q.push_back(e);
                model_cnt = (model_cnt + 1) % NUM_CH;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // One isolated beat with out_ready high; returns the outputs and the
    // number of clock edges from presentation until out_valid.
    task automatic one_beat(input logic [31:0] d, input logic clr,
                            output logic [15:0] r0, output logic [15:0] r4,
                            output int ch, output int lat);
        in_valid = 1'b1; in_data = d; ch_clr = clr; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; ch_clr = 1'b0;
        lat = 1;
        while (!bus0.out_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        r0 = bus0.out_data; r4 = bus4.out_data; ch = int'(bus0.out_ch);
        @(posedge clk); #1;
    endtask

    // n back-to-back beats of zero data, ch_clr with the first if asked.
    task automatic fill(input int n, input logic clr_first);
        out_ready = 1'b1;
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1; in_data = '0; ch_clr = clr_first && (k == 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; ch_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_data();
        case ($urandom_range(3))
            0:       return $urandom;
            1:       return 32'(int'($urandom_range(80000)) - 40000);
            2:       return 32'(int'($urandom_range(34000, 31000)));
            default: return 32'(int'($urandom_range(400)) - 200);
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] r0, r4;
        int ch, lat, i, cyc, n_out0;
        logic acc;

        for (int k = 0; k < NUM_CH; k++) bias_mem[k] = 16'($urandom);
        bias_mem[0]  = 16'h805E;   // -94
        bias_mem[2]  = 16'h001A;   // +26
        bias_mem[5]  = 16'h8000;   // negative zero
        bias_mem[37] = 16'h02A6;   // +678

        #1;
        chk("rst_out_valid", {63'd0, bus0.out_valid}, 64'd0);
        chk("rst_out_data", {48'd0, bus0.out_data}, 64'd0);
        chk("rst_out_ch", {58'd0, bus0.out_ch}, 64'd0);
        chk("rst_out_last", {63'd0, bus0.out_last}, 64'd0);
        chk("rst_in_ready", {63'd0, bus0.in_ready}, 64'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // ch0: 100 - 94 = 6, two-edge latency
        one_beat(32'd100, 1'b0, r0, r4, ch, lat);
        chk("ch0_data", 64'(r0), 64'd6);
        chk("ch0_tag", 64'(ch), 64'd0);
        chk("ch0_latency", 64'(lat), 64'd2);
        chk("ch0_shr4", 64'(r4), 64'd0);

        // ch0 again via ch_clr: 0 - 94 < 0 -> ReLU
        one_beat(32'd0, 1'b1, r0, r4, ch, lat);
        chk("relu_data", 64'(r0), 64'd0);
        chk("relu_tag", 64'(ch), 64'd0);
`ifdef FIRE7_SQ_SAT_CNT_EN
        chk("relu_cnt", 64'(relu0), 64'd1);
`endif

        // ch37: 32767 + 678 saturates; OUT_SHR=4 gives (33445+8)>>4 = 2090
        fill(37, 1'b1);
        one_beat(32'd32767, 1'b0, r0, r4, ch, lat);
        chk("sat_data", 64'(r0), 64'd32767);
        chk("sat_tag", 64'(ch), 64'd37);
        chk("sat_shr4", 64'(r4), 64'd2090);
`ifdef FIRE7_SQ_SAT_CNT_EN
        chk("sat_cnt", 64'(sat0), 64'd1);
`endif

        // ch2: 22 + 26 = 48; OUT_SHR=4 gives (48+8)>>4 = 3
        fill(2, 1'b1);
        one_beat(32'd22, 1'b0, r0, r4, ch, lat);
        chk("ch2_data", 64'(r0), 64'd48);
        chk("ch2_shr4", 64'(r4), 64'd3);

        // ch5 bias 0x8000 (negative zero) leaves data unchanged
        fill(2, 1'b0);
        one_beat(32'd5, 1'b0, r0, r4, ch, lat);
        chk("negzero_data", 64'(r0), 64'd5);
        chk("negzero_tag", 64'(ch), 64'd5);

        // ch_clr with the beat at ch10: tagged 0, next beat tagged 1
        fill(4, 1'b0);
        one_beat(32'd77, 1'b1, r0, r4, ch, lat);
        chk("clr_tag", 64'(ch), 64'd0);
        one_beat(32'd77, 1'b0, r0, r4, ch, lat);
        chk("clr_next_tag", 64'(ch), 64'd1);

        // Reset with both stages full: out_valid drops immediately, no output after
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'd1000;
        @(posedge clk); #1;
        in_data = 32'd2000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("prerst_out_valid", {63'd0, bus0.out_valid}, 64'd1);
        #2 rst = 1'b1;
        #1 chk("async_rst_out_valid", {63'd0, bus0.out_valid}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        n_out0 = n_out;
        repeat (6) @(posedge clk);
        #1;
        chk("post_rst_outputs", 64'(n_out - n_out0), 64'd0);

        // 65 beats back-to-back with out_ready toggling 1010...
        n_out0 = n_out;
        i = 0; cyc = 0;
        while (i < 65 && cyc < 400) begin
            ch_clr = (i == 0);
            in_valid = 1'b1;
            in_data = rand_data();
            out_ready = (cyc % 2 == 0);
            acc = bus0.in_ready;
            @(posedge clk); #1;
            if (acc) i++;
            cyc++;
        end
        in_valid = 1'b0; ch_clr = 1'b0; out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("b2b_accepted", 64'(i), 64'd65);
        chk("b2b_outputs", 64'(n_out - n_out0), 64'd65);

        // Randomized traffic with random backpressure and occasional ch_clr
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(3) != 0);
            in_data   = rand_data();
            out_ready = ($urandom_range(2) != 0);
            ch_clr    = ($urandom_range(63) == 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; ch_clr = 1'b0; out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("drain_out_valid", {63'd0, bus0.out_valid}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fire7_squeeze_bias_relu.md
Name: fire7_squeeze_bias_relu

Overview:
- Post-accumulation stage of the fire7 squeeze layer, directly downstream of the squeeze bias ROM.
- Consumes one signed accumulator word per output channel, in channel order 0..NUM_CH-1 per pixel.
- Adds the channel's sign-magnitude bias, rounds and shifts, applies ReLU, saturates, and streams the result to the expand-stage input buffer.
- Two-stage valid/ready pipeline with full backpressure.

Parameters:
- ACC_W, 32, accumulator input width, two's complement.
- OUT_W, 16, output activation width, two's complement (always non-negative after ReLU).
- NUM_CH, 64, squeeze channels per pixel.
- BIAS_SHL, 0, left shift aligning bias to accumulator scale; 16+BIAS_SHL <= ACC_W.
- OUT_SHR, 0, right shift from accumulator scale to output scale, round-half-up.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- bias_mem  in  16 x NUM_CH  bias table; bit15 = sign, bits14:0 = magnitude.
- ch_clr  in  1  synchronous restart of the channel counter (new frame).
- in_valid  in  1  accumulator word valid.
- in_ready  out  1  stage can accept.
- in_data  in  ACC_W  accumulator word for the current channel.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_data  out  OUT_W  activation.
- out_ch  out  $clog2(NUM_CH)  channel index of out_data.
- out_last  out  1  out_ch == NUM_CH-1.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - All valids, the channel counter, out_data, out_ch and out_last go to 0.
  - Reset mid-transfer discards in-flight data with no output.
- Channel counter: increments on each in_valid&&in_ready and wraps from NUM_CH-1 to 0.
  - ch_clr forces the counter to 0.
  - If ch_clr and an accepted beat occur together, that beat is tagged channel 0 and the counter becomes 1.
- Bias conversion: sign-magnitude to two's complement, sign-extended to ACC_W+1, then shifted left by BIAS_SHL.
  - 0x8000 (negative zero) yields 0.
- S1 (registered): sum = sext(in_data, ACC_W+1) + bias. Stores the channel tag. No overflow is possible at this width.
- S2 (registered):
  - If OUT_SHR > 0, add 2^(OUT_SHR-1), then arithmetic shift right by OUT_SHR.
  - If the result is negative, output 0 (ReLU).
  - If the result exceeds 2^(OUT_W-1)-1, output 2^(OUT_W-1)-1.
- Handshake:
  - s1_ready = !s2_valid || out_ready.
  - in_ready = !s1_valid || s1_ready.
  - Outputs hold stable while out_valid && !out_ready.
  - in_ready never depends combinationally on in_valid.
- Latency: 2 cycles from acceptance to out_valid with no stall. Throughput: 1 word/cycle.
- Data leaves in acceptance order; no reordering or drops.

Optional Feature:
- Macro: FIRE7_SQ_SAT_CNT_EN.
- Defined:
  - Adds output sat_cnt (16 bits): counts S2 results clipped high; saturates at 0xFFFF; clears on rst or ch_clr.
  - Adds output relu_cnt (16 bits): counts results zeroed by ReLU; same saturation and clear rules.
  - Counters update only when a word moves S1 to S2.
- Undefined: neither port exists and no counter logic is generated.

Decomposition:
- Package fire7_sq_pkg holds:
  - NUM_CH, BIAS_W = 16.
  - Function sm_to_tc (sign-magnitude to two's complement).
  - Typedef ch_idx_t.
- Sub-module fire7_sq_requant: combinational round/shift/ReLU/saturate, instantiated at S2, reusable for the expand layers.

Test Plan:
- Defaults, ch0 (bias 0x805E = -94), in_data 100 -> out_data 6, out_ch 0, out_valid 2 cycles after acceptance.
- ch0, in_data 0 -> out_data 0 (ReLU). With FIRE7_SQ_SAT_CNT_EN, relu_cnt = 1.
- ch37 (bias 0x02A6 = +678), in_data 32767 -> out_data 32767 saturated. With the macro, sat_cnt = 1.
- 64 back-to-back beats with out_ready toggled 1010…:
  - Outputs are ordered and gap-free relative to stalls.
  - out_last only on ch63.
  - Beat 65 is tagged ch0.
  - No loss or duplication.
- ch_clr asserted with the accepted beat at ch10 -> that beat tagged ch0, the next beat ch1. Reset asserted while s1_valid = s2_valid = 1 -> out_valid = 0 immediately, no spurious output after release.
- OUT_SHR = 4, ch2 (bias +26), in_data 22 -> sum 48 -> (48+8)>>4 = 3. Bias 0x8000 with in_data 5 -> out_data 5 at OUT_SHR = 0.
